// File: rtl/md_unit.sv
// ============================================================================
// Module   : md_unit
// Purpose  : Multi-cycle multiply/divide unit for the E stage. Holds the
//            architectural HI/LO registers and serves mult/multu/div/divu,
//            mthi/mtlo and mfhi/mflo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDOp,
   input  logic [31:0] E_Op1,
   input  logic [31:0] E_Op2,
   output logic        E_Start,
   output logic        E_Busy,
   output logic [31:0] E_MDResult
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] c_MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] c_DIV_LOAD  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);

   localparam logic [3:0] c_OP_MULT  = 4'd1;
   localparam logic [3:0] c_OP_MULTU = 4'd2;
   localparam logic [3:0] c_OP_DIV   = 4'd3;
   localparam logic [3:0] c_OP_DIVU  = 4'd4;
   localparam logic [3:0] c_OP_MTHI  = 4'd5;
   localparam logic [3:0] c_OP_MTLO  = 4'd6;
   localparam logic [3:0] c_OP_MFHI  = 4'd7;
   localparam logic [3:0] c_OP_MFLO  = 4'd8;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic [31:0]   tmp_hi_q, tmp_hi_d;
   logic [31:0]   tmp_lo_q, tmp_lo_d;
   logic          commit_q, commit_d;

   // Arithmetic datapath, evaluated on the operands present at the start edge
   logic [63:0] w_op1_sx, w_op2_sx;
   logic [63:0] w_sprod, w_uprod;
   logic        w_div_zero, w_sdiv_ovf;
   logic [31:0] w_sdivisor, w_udivisor;
   logic [31:0] w_squot, w_srem, w_uquot, w_urem;
   logic        w_is_md;

   // The low 64 bits of a product of sign-extended operands equal the signed product
   assign w_op1_sx = {{32{E_Op1[31]}}, E_Op1};
   assign w_op2_sx = {{32{E_Op2[31]}}, E_Op2};
   assign w_sprod  = w_op1_sx * w_op2_sx;
   assign w_uprod  = {32'd0, E_Op1} * {32'd0, E_Op2};

   // Divisors are steered to 1 for the zero case (result discarded) and for the
   // signed overflow case, where x/1 yields exactly the required 0x80000000 rem 0
   assign w_div_zero = (E_Op2 == 32'd0);
   assign w_sdiv_ovf = (E_Op1 == 32'h8000_0000) && (E_Op2 == 32'hFFFF_FFFF);
   assign w_sdivisor = (w_div_zero || w_sdiv_ovf) ? 32'd1 : E_Op2;
   assign w_udivisor = w_div_zero ? 32'd1 : E_Op2;
   assign w_squot    = $signed(E_Op1) / $signed(w_sdivisor);
   assign w_srem     = $signed(E_Op1) % $signed(w_sdivisor);
   assign w_uquot    = E_Op1 / w_udivisor;
   assign w_urem     = E_Op1 % w_udivisor;

   assign w_is_md = (E_MDOp >= c_OP_MULT) && (E_MDOp <= c_OP_DIVU);
   assign E_Start = w_is_md && !busy_q;
   assign E_Busy  = busy_q;

   // Next-state: start loads counter and temps, countdown commits on 1->0, moves when idle
   always_comb begin
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      tmp_hi_d = tmp_hi_q;
      tmp_lo_d = tmp_lo_q;
      commit_d = commit_q;
      if (E_Start) begin
         commit_d = 1'b1;
         unique case (E_MDOp)
            c_OP_MULT: begin
               cnt_d    = c_MULT_LOAD;
               tmp_hi_d = w_sprod[63:32];
               tmp_lo_d = w_sprod[31:0];
            end
            c_OP_MULTU: begin
               cnt_d    = c_MULT_LOAD;
               tmp_hi_d = w_uprod[63:32];
               tmp_lo_d = w_uprod[31:0];
            end
            c_OP_DIV: begin
               cnt_d    = c_DIV_LOAD;
               tmp_hi_d = w_srem;
               tmp_lo_d = w_squot;
               commit_d = !w_div_zero;
            end
            default: begin
               cnt_d    = c_DIV_LOAD;
               tmp_hi_d = w_urem;
               tmp_lo_d = w_uquot;
               commit_d = !w_div_zero;
            end
         endcase
      end else if (busy_q) begin
         cnt_d = cnt_q - c_CNT_ONE;
         if (cnt_q == c_CNT_ONE && commit_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
         end
      end else if (E_MDOp == c_OP_MTHI) begin
         hi_d = E_Op1;
      end else if (E_MDOp == c_OP_MTLO) begin
         lo_d = E_Op1;
      end
   end

   // State registers; reset discards any in-flight operation
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         tmp_hi_q <= 32'd0;
         tmp_lo_q <= 32'd0;
         commit_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         busy_q   <= (cnt_d != '0);
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         tmp_hi_q <= tmp_hi_d;
         tmp_lo_q <= tmp_lo_d;
         commit_q <= commit_d;
      end
   end

   // Read port for mfhi/mflo
   always_comb begin
      E_MDResult = 32'd0;
      if (E_MDOp == c_OP_MFHI) begin
         E_MDResult = hi_q;
      end else if (E_MDOp == c_OP_MFLO) begin
         E_MDResult = lo_q;
      end
   end

endmodule

`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit for the E stage of the five-stage MIPS pipeline; sits beside the ALU and consumes the forwarded E-stage operands.
- Executes mult, multu, div and divu over several cycles, and holds the architectural HI/LO registers.
- Serves mfhi, mflo, mthi and mtlo.
- Exposes start/busy so the hazard unit can stall D-stage MD instructions while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy duration in cycles for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
E_MDOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 treated as none
E_Op1  input  32  forwarded rs value (E_for_rs)
E_Op2  input  32  forwarded rt value (E_for_rt)
E_Start  output  1  combinational: 1 when E_MDOp is 1..4 and E_Busy=0
E_Busy  output  1  registered: operation in flight
E_MDResult  output  32  combinational: HI when mfhi, LO when mflo, else 0

Behaviour:
- Reset (reset=0, async): HI=0, LO=0, cycle counter=0, E_Busy=0, temp product/quotient regs=0. Any in-flight operation is discarded; HI/LO are not updated.
- State: a counter drives the state, and E_Busy = (counter != 0).
  - IDLE: counter=0.
  - RUN: counter=N..1.
- Start, accepted at edge T when E_Start=1:
  - Compute the result from E_Op1/E_Op2 into tempHI/tempLO.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - E_Busy is high for cycles T+1..T+N.
  - The counter decrements each edge. On the 1->0 edge, HI<=tempHI and LO<=tempLO.
  - New HI/LO are visible on E_MDResult from cycle T+N+1.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI = upper word, LO = lower word.
  - multu: same, unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - divu: unsigned quotient/remainder.
- Divide by zero (div/divu, E_Op2=0): the full DIV_CYCLES busy period still runs, then HI/LO are left unchanged (no commit).
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo write HI/LO from E_Op1 at the next edge, only when E_Busy=0. While busy they are ignored; the hazard unit guarantees this does not happen.
- mfhi/mflo read HI/LO combinationally. During busy they return the pre-operation values; the hazard unit must stall them.
- Ops 1..4 arriving while E_Busy=1: E_Start=0, the op is ignored, and the in-flight op is unaffected.
- Ops 1..4 in the same cycle the counter goes 1->0: E_Busy is still 1, so the op is ignored. The hazard unit stalls on E_Busy.
- The block has no flush input. A bubble from E_Flush arrives as E_MDOp=0 and causes no action.

Test Plan:
- Signed mult: mult, Op1=0xFFFFFFFF, Op2=2 -> E_Busy high exactly 5 cycles; then mfhi=0xFFFFFFFF, mflo=0xFFFFFFFE.
- Unsigned mult: multu, same operands -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE; mfhi during busy returns the old HI.
- Signed div: div, -7 (0xFFFFFFF9) / 2 -> E_Busy high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Unsigned div and divide by zero: divu 7/2 -> LO=3, HI=1; then divu 7/0 -> busy 10 cycles, HI=1, LO=3 unchanged.
- Move and busy-ignore: mthi 0x1234 then mtlo 0x5678 while idle -> mfhi=0x1234, mflo=0x5678. mult issued during a busy div -> E_Start=0 and the div result is unaffected.
- Reset mid-operation: assert reset=0 asynchronously mid-clock in cycle 3 of a mult -> E_Busy=0 and HI=LO=0 immediately; after release, no late commit occurs.
